// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response/state types and window decode for the AXI-Lite slave bridge
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  // Subtract before comparing so base+span may sit at the top of the address space.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/axi_lite_slv_timer.sv
// rtl/axi_lite_slv_timer.sv - loadable down-counter with expired flag for backend wait limits
module axi_lite_slv_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/axi_lite_slave_bridge.sv
// rtl/axi_lite_slave_bridge.sv - AXI4-Lite slave terminating into a valid/ready register backend
// Optional backend wait limit: define AXI_LITE_SLV_TIMEOUT_EN.
module axi_lite_slave_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned     ADDR_W         = 32,
  parameter int unsigned     DATA_W         = 32,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter longint unsigned SPAN           = 4096,
  parameter int unsigned     TIMEOUT_CYCLES = 256,
  localparam int unsigned    STRB_W         = DATA_W / 8,
  localparam int unsigned    OFF_W          = $clog2(SPAN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [OFF_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [STRB_W-1:0] wr_strb,
  input  logic [1:0]        wr_resp,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [OFF_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        rd_resp
);

  if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_data_w
    $error("axi_lite_slave_bridge: DATA_W must be 32 or 64");
  end
  if (((SPAN & (SPAN - 1)) != 0) || (SPAN < STRB_W)) begin : g_bad_span
    $error("axi_lite_slave_bridge: SPAN must be a power of two >= DATA_W/8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi_lite_slave_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  // Window-relative, bus-aligned backend address; unaligned low bits are dropped.
  function automatic logic [OFF_W-1:0] backend_addr(input logic [ADDR_W-1:0] addr);
    return OFF_W'(addr - ADDR_W'(BASE_ADDR)) & ~OFF_W'(STRB_W - 1);
  endfunction

  wr_state_t         wst_q, wst_d;
  logic              have_aw_q, have_aw_d, have_w_q, have_w_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d, wr_valid_q, wr_valid_d;
  resp_t             bresp_q, bresp_d;
  logic [OFF_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;

  rd_state_t         rdst_q, rdst_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rd_valid_q, rd_valid_d;
  resp_t             rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [OFF_W-1:0]  rd_addr_q, rd_addr_d;

`ifdef AXI_LITE_SLV_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic wr_expired, rd_expired;

  axi_lite_slv_timer #(.CNT_W(TMR_W)) u_wr_timer (
    .clk      (clk),
    .rst      (rst),
    .load     ((wst_q != W_REQ) && (wst_d == W_REQ)),
    .load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
    .en       (wst_q == W_REQ),
    .expired  (wr_expired)
  );

  axi_lite_slv_timer #(.CNT_W(TMR_W)) u_rd_timer (
    .clk      (clk),
    .rst      (rst),
    .load     ((rdst_q != R_REQ) && (rdst_d == R_REQ)),
    .load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
    .en       (rdst_q == R_REQ),
    .expired  (rd_expired)
  );
`endif

  // Write path: AW and W are collected independently, then decoded together.
  always_comb begin
    wst_d      = wst_q;
    have_aw_d  = have_aw_q;
    have_w_d   = have_w_q;
    awaddr_d   = awaddr_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    case (wst_q)
      W_IDLE: begin
        if (s_awvalid && awready_q) begin
          have_aw_d = 1'b1;
          awaddr_d  = s_awaddr;
        end
        if (s_wvalid && wready_q) begin
          have_w_d  = 1'b1;
          wr_data_d = s_wdata;
          wr_strb_d = s_wstrb;
        end
        if (have_aw_d && have_w_d) begin
          have_aw_d = 1'b0;
          have_w_d  = 1'b0;
          if (in_window(64'(awaddr_d), BASE_ADDR, SPAN)) begin
            wst_d      = W_REQ;
            wr_valid_d = 1'b1;
            wr_addr_d  = backend_addr(awaddr_d);
          end else begin
            wst_d    = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = DECERR;
          end
        end
      end
      W_REQ: begin
        if (wr_ready) begin
          wst_d      = W_RESP;
          wr_valid_d = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = resp_t'(wr_resp);
        end
`ifdef AXI_LITE_SLV_TIMEOUT_EN
        else if (wr_expired) begin
          wst_d      = W_RESP;
          wr_valid_d = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = SLVERR;
        end
`endif
      end
      W_RESP: begin
        if (s_bready) begin
          wst_d    = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wst_d = W_IDLE;
    endcase
    awready_d = (wst_d == W_IDLE) && !have_aw_d;
    wready_d  = (wst_d == W_IDLE) && !have_w_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wst_q      <= W_IDLE;
      have_aw_q  <= 1'b0;
      have_w_q   <= 1'b0;
      awaddr_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      wst_q      <= wst_d;
      have_aw_q  <= have_aw_d;
      have_w_q   <= have_w_d;
      awaddr_q   <= awaddr_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
    end
  end

  always_comb begin
    rdst_d     = rdst_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    case (rdst_q)
      R_IDLE: begin
        if (s_arvalid && arready_q) begin
          if (in_window(64'(s_araddr), BASE_ADDR, SPAN)) begin
            rdst_d     = R_REQ;
            rd_valid_d = 1'b1;
            rd_addr_d  = backend_addr(s_araddr);
          end else begin
            rdst_d   = R_RESP;
            rvalid_d = 1'b1;
            rresp_d  = DECERR;
            rdata_d  = '0;
          end
        end
      end
      R_REQ: begin
        if (rd_ready) begin
          rdst_d     = R_RESP;
          rd_valid_d = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = resp_t'(rd_resp);
          rdata_d    = rd_data;
        end
`ifdef AXI_LITE_SLV_TIMEOUT_EN
        else if (rd_expired) begin
          rdst_d     = R_RESP;
          rd_valid_d = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = SLVERR;
          rdata_d    = '0;
        end
`endif
      end
      R_RESP: begin
        if (s_rready) begin
          rdst_d   = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rdst_d = R_IDLE;
    endcase
    arready_d = (rdst_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdst_q     <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      rdst_q     <= rdst_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strb   = wr_strb_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// tb/tb_axi_lite_slave_bridge.sv - directed and randomized self-checking bench for axi_lite_slave_bridge
module tb_axi_lite_slave_bridge;

  localparam int unsigned     ADDR_W = 32;
  localparam int unsigned     DATA_W = 32;
  localparam int unsigned     STRB_W = 4;
  localparam int unsigned     OFF_W  = 8;
  localparam longint unsigned BASE   = 64'h2000;
  localparam longint unsigned SPAN   = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0;
  logic              s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
  logic              s_arvalid = 1'b0, s_rready = 1'b0;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [STRB_W-1:0] s_wstrb = '0;
  logic              s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]        s_bresp, s_rresp;
  logic [DATA_W-1:0] s_rdata;
  logic              wr_valid, rd_valid;
  logic              wr_ready = 1'b0, rd_ready = 1'b0;
  logic [OFF_W-1:0]  wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [1:0]        wr_resp = '0, rd_resp = '0;
  logic [DATA_W-1:0] rd_data = '0;

  axi_lite_slave_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .SPAN(SPAN), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_resp(wr_resp),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_resp(rd_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: window decode and backend address from plain arithmetic.
  function automatic bit in_win(input logic [ADDR_W-1:0] a);
    longint unsigned x;
    x = a;
    return (x >= BASE) && (x < BASE + SPAN);
  endfunction

  function automatic logic [OFF_W-1:0] exp_off(input logic [ADDR_W-1:0] a);
    longint unsigned x;
    x = a;
    return OFF_W'((x - BASE) / STRB_W * STRB_W);
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return ADDR_W'(BASE + SPAN + $urandom_range(0, 64));
      1:       return ADDR_W'(BASE - 1 - $urandom_range(0, 64));
      default: return ADDR_W'(BASE + $urandom_range(0, 255));
    endcase
  endfunction

  logic [OFF_W+DATA_W+STRB_W-1:0] exp_wr_q[$];
  logic [OFF_W-1:0]               exp_rd_q[$];
  logic [1:0]                     exp_b_q[$];
  logic [DATA_W+1:0]              exp_r_q[$];

  // Randomized backend; a request never waits more than three cycles.
  bit bk_rand = 0;
  initial begin
    int wr_lo, rd_lo;
    wr_lo = 0;
    rd_lo = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bk_rand) begin
        wr_ready = (wr_lo >= 3) || ($urandom_range(0, 2) != 0);
        wr_lo    = wr_ready ? 0 : wr_lo + 1;
        rd_ready = (rd_lo >= 3) || ($urandom_range(0, 2) != 0);
        rd_lo    = rd_ready ? 0 : rd_lo + 1;
        wr_resp  = 2'($urandom_range(0, 3));
        rd_resp  = 2'($urandom_range(0, 3));
        rd_data  = $urandom;
      end
    end
  end

  // Compare process: stability, no unexpected requests/responses, payloads vs model.
  bit mon_en = 0;
  initial begin
    bit hold_b, hold_r, hold_wr, hold_rd;
    logic [1:0] p_bresp;
    logic [DATA_W+1:0] p_r;
    logic [OFF_W+DATA_W+STRB_W-1:0] p_wr;
    logic [OFF_W-1:0] p_rda;
    hold_b = 0; hold_r = 0; hold_wr = 0; hold_rd = 0;
    p_bresp = '0; p_r = '0; p_wr = '0; p_rda = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold_b) begin
          chk("b_stable_valid", s_bvalid, 1);
          chk("b_stable_resp", s_bresp, p_bresp);
        end
        if (hold_r) begin
          chk("r_stable_valid", s_rvalid, 1);
          chk("r_stable_payload", {s_rdata, s_rresp}, p_r);
        end
        if (hold_wr) begin
          chk("wr_stable_valid", wr_valid, 1);
          chk("wr_stable_payload", {wr_addr, wr_data, wr_strb}, p_wr);
        end
        if (hold_rd) begin
          chk("rd_stable_valid", rd_valid, 1);
          chk("rd_stable_addr", rd_addr, p_rda);
        end
        if (wr_valid) begin
          chk("wr_req_expected", exp_wr_q.size() > 0, 1);
          if (wr_ready && exp_wr_q.size() > 0) begin
            chk("wr_payload", {wr_addr, wr_data, wr_strb}, exp_wr_q.pop_front());
            exp_b_q.push_back(wr_resp);
          end
        end
        if (rd_valid) begin
          chk("rd_req_expected", exp_rd_q.size() > 0, 1);
          if (rd_ready && exp_rd_q.size() > 0) begin
            chk("rd_addr", rd_addr, exp_rd_q.pop_front());
            exp_r_q.push_back({rd_data, rd_resp});
          end
        end
        if (s_bvalid) begin
          chk("b_expected", exp_b_q.size() > 0, 1);
          if (s_bready && exp_b_q.size() > 0) chk("bresp", s_bresp, exp_b_q.pop_front());
        end
        if (s_rvalid) begin
          chk("r_expected", exp_r_q.size() > 0, 1);
          if (s_rready && exp_r_q.size() > 0) chk("rdata_rresp", {s_rdata, s_rresp}, exp_r_q.pop_front());
        end
      end
      hold_b  = s_bvalid && !s_bready;
      hold_r  = s_rvalid && !s_rready;
      hold_wr = wr_valid && !wr_ready;
      hold_rd = rd_valid && !rd_ready;
      p_bresp = s_bresp;
      p_r     = {s_rdata, s_rresp};
      p_wr    = {wr_addr, wr_data, wr_strb};
      p_rda   = rd_addr;
    end
  end

  task automatic wr_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [STRB_W-1:0] s, input int daw, input int dw);
    bit aw_done, w_done;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    while (!(aw_done && w_done)) begin
      s_awvalid = !aw_done && (c >= daw);
      s_wvalid  = !w_done && (c >= dw);
      @(negedge clk);
      if (s_awvalid && s_awready) aw_done = 1;
      if (s_wvalid && s_wready) w_done = 1;
      if (aw_done && w_done) begin
        if (in_win(a)) exp_wr_q.push_back({exp_off(a), d, s});
        else exp_b_q.push_back(2'd3);
      end
      tick();
      c++;
      if (c > 200) begin fail("wr_capture_wait"); break; end
    end
    s_awvalid = 0; s_wvalid = 0;
    c = 0;
    forever begin
      s_bready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_bvalid && s_bready) begin tick(); break; end
      tick();
      c++;
      if (c > 200) begin fail("b_wait"); break; end
    end
    s_bready = 0;
  endtask

  task automatic rd_txn(input logic [ADDR_W-1:0] a, input int dar);
    int c;
    c = 0;
    s_araddr = a;
    for (int i = 0; i < dar; i++) tick();
    s_arvalid = 1;
    forever begin
      @(negedge clk);
      if (s_arready) begin
        if (in_win(a)) exp_rd_q.push_back(exp_off(a));
        else exp_r_q.push_back({{DATA_W{1'b0}}, 2'd3});
        tick();
        break;
      end
      tick();
      c++;
      if (c > 200) begin fail("ar_capture_wait"); break; end
    end
    s_arvalid = 0;
    c = 0;
    forever begin
      s_rready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_rvalid && s_rready) begin tick(); break; end
      tick();
      c++;
      if (c > 200) begin fail("r_wait"); break; end
    end
    s_rready = 0;
  endtask

  task automatic wr_master(input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = rand_addr();
      wr_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic rd_master(input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = rand_addr();
      rd_txn(a, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and ready rise on the first edge after deassertion.
    @(negedge clk);
    chk("rst_awready", s_awready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_valids", {s_bvalid, s_rvalid, wr_valid, rd_valid}, 0);
    chk("rst_payload", {s_bresp, s_rresp, s_rdata, wr_addr, wr_data, wr_strb, rd_addr}, 0);
    tick();
    rst = 1;
    @(negedge clk);
    chk("ready_before_edge", {s_awready, s_wready, s_arready}, 0);
    tick();
    @(negedge clk);
    chk("ready_after_edge", {s_awready, s_wready, s_arready}, 3'b111);

    // Same-cycle AW+W, backend ready.
    tick();
    wr_ready = 1; wr_resp = 2'd0;
    s_awaddr = ADDR_W'(BASE + 'h10); s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    chk("t1_wr_valid", wr_valid, 1);
    chk("t1_wr_addr", wr_addr, 8'h10);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_wr_strb", wr_strb, 4'hF);
    chk("t1_bvalid_early", s_bvalid, 0);
    chk("t1_awready_busy", s_awready, 0);
    tick();
    s_bready = 1;
    @(negedge clk);
    chk("t1_wr_valid_drop", wr_valid, 0);
    chk("t1_bvalid", s_bvalid, 1);
    chk("t1_bresp", s_bresp, 2'd0);
    tick();
    s_bready = 0;
    @(negedge clk);
    chk("t1_b_done", s_bvalid, 0);
    chk("t1_awready_back", s_awready, 1);

    // W first, AW three cycles later, unaligned address, SLVERR passthrough.
    tick();
    wr_resp = 2'd2;
    s_wdata = 32'hCAFE0001; s_wstrb = 4'h3; s_wvalid = 1;
    tick();
    s_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_no_req_before_aw", wr_valid, 0);
      chk("t2_wready_dropped", s_wready, 0);
      tick();
    end
    s_awaddr = ADDR_W'(BASE + 'h0A); s_awvalid = 1;
    tick();
    s_awvalid = 0;
    @(negedge clk);
    chk("t2_wr_valid", wr_valid, 1);
    chk("t2_wr_addr", wr_addr, 8'h08);
    chk("t2_wr_strb", wr_strb, 4'h3);
    chk("t2_wr_data", wr_data, 32'hCAFE0001);
    tick();
    s_bready = 1;
    @(negedge clk);
    chk("t2_bresp", {s_bvalid, s_bresp}, 3'b110);
    tick();
    s_bready = 0;

    // Out-of-window read at the top edge and write just below the base.
    rd_ready = 1; rd_data = 32'hFFFFFFFF;
    s_araddr = ADDR_W'(BASE + SPAN); s_arvalid = 1;
    tick();
    s_arvalid = 0;
    @(negedge clk);
    chk("t3_rvalid", s_rvalid, 1);
    chk("t3_rresp", s_rresp, 2'd3);
    chk("t3_rdata", s_rdata, 0);
    chk("t3_no_rd_req", rd_valid, 0);
    s_rready = 1;
    tick();
    s_rready = 0;
    @(negedge clk);
    chk("t3_r_done", {s_rvalid, s_arready}, 2'b01);
    tick();
    s_awaddr = ADDR_W'(BASE - 4); s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    chk("t3_w_decerr", {s_bvalid, s_bresp, wr_valid}, 4'b1110);
    s_bready = 1;
    tick();
    s_bready = 0;

    // Backend wait states, then response held until rready.
    rd_ready = 0;
    s_araddr = ADDR_W'(BASE + 'h23); s_arvalid = 1;
    tick();
    s_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_rd_valid_held", rd_valid, 1);
      chk("t4_rd_addr", rd_addr, 8'h20);
      chk("t4_rvalid_early", s_rvalid, 0);
      tick();
    end
    rd_ready = 1; rd_data = 32'h1234; rd_resp = 2'd0;
    tick();
    rd_ready = 0; rd_data = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      s_rready = (i == 2);
      @(negedge clk);
      chk("t4_rvalid", s_rvalid, 1);
      chk("t4_rdata", s_rdata, 32'h1234);
      chk("t4_rresp", s_rresp, 2'd0);
      tick();
    end
    s_rready = 0;
    @(negedge clk);
    chk("t4_r_done", s_rvalid, 0);

`ifdef AXI_LITE_SLV_TIMEOUT_EN
    tick();
    wr_ready = 0;
    s_awaddr = ADDR_W'(BASE + 'h44); s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_wr_valid_held", wr_valid, 1);
      tick();
    end
    @(negedge clk);
    chk("tmo_wr_valid_drop", wr_valid, 0);
    chk("tmo_bresp", {s_bvalid, s_bresp}, 3'b110);
    s_bready = 1;
    tick();
    s_bready = 0;
`endif

    // Asynchronous reset while a write request is pending.
    tick();
    wr_ready = 0;
    s_awaddr = ADDR_W'(BASE + 'h40); s_wdata = 32'hA5A5A5A5; s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    chk("t6_wr_pending", wr_valid, 1);
    #2;
    rst = 0;
    #1;
    chk("t6_rst_wr", {wr_valid, wr_addr, wr_data, wr_strb}, 0);
    chk("t6_rst_ready", {s_awready, s_wready, s_arready}, 0);
    chk("t6_rst_resp", {s_bvalid, s_bresp, s_rvalid}, 0);
    tick();
    rst = 1;
    wr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_response", {s_bvalid, wr_valid}, 0);
      tick();
    end

    // Randomized concurrent traffic against the model.
    mon_en = 1;
    bk_rand = 1;
    fork
      wr_master(40);
      rd_master(40);
    join
    repeat (4) tick();
    mon_en = 0;
    bk_rand = 0;
    chk("end_wr_q_empty", exp_wr_q.size(), 0);
    chk("end_rd_q_empty", exp_rd_q.size(), 0);
    chk("end_b_q_empty", exp_b_q.size(), 0);
    chk("end_r_q_empty", exp_r_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
